// File: rtl/axis_xk_tx_if.sv
// AXI-Stream channel carrying packed {K lanes, X lanes} beats from axis_xk_tx.
// The master modport drives TVALID/TDATA/TLAST; the slave modport drives TREADY.
interface axis_xk_tx_if #(
    parameter int WB = 64
);
    logic          m_valid;
    logic          m_ready;
    logic [WB-1:0] m_data;
    logic          m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/axis_xk_tx.sv
// K-row beat buffer replayed as one AXI-Stream packet per start pulse.
// Optional AXIS_XK_TX_LOOP_EN adds a loop input that restarts the packet with no bubble.
module axis_xk_tx #(
    parameter  int R  = 4,
    parameter  int C  = 4,
    parameter  int K  = 8,
    parameter  int WX = 8,
    parameter  int WK = 8,
    localparam int WB = WX*R + WK*C,
    localparam int WA = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          w_en,
    input  logic [WA-1:0] w_addr,
    input  logic [WB-1:0] w_data,
    input  logic          start,
`ifdef AXIS_XK_TX_LOOP_EN
    input  logic          loop,
`endif
    output logic          busy,
    output logic          done,
    axis_xk_tx_if.master  m_axis
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [WA-1:0] LAST_IDX = WA'(K - 1);
    localparam logic [WA:0]   ADDR_LIM = (WA+1)'(K);
    localparam logic          ONE_BEAT = (K == 1);

    state_t        r_state;
    logic [WA-1:0] r_cnt;
    logic          r_valid;
    logic          r_last;
    logic [WB-1:0] r_data;
    logic          r_done;
    logic [WB-1:0] r_mem [K];

    logic [WA-1:0] w_next;
    logic          w_hs;
    logic          w_loop;

    assign w_next = r_cnt + 1'b1;
    assign w_hs   = r_valid && m_axis.m_ready;

`ifdef AXIS_XK_TX_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    // Buffer has no reset; writes are locked out for the whole packet.
    always_ff @(posedge clk) begin
        if (w_en && (r_state == IDLE) && ({1'b0, w_addr} < ADDR_LIM)) begin
            r_mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SEND;
                        r_data  <= r_mem[0];
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_last  <= ONE_BEAT;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_cnt == LAST_IDX) begin
                            r_done <= 1'b1;
                            if (w_loop) begin
                                r_data <= r_mem[0];
                                r_cnt  <= '0;
                                r_last <= ONE_BEAT;
                            end else begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                            end
                        end else begin
                            r_data <= r_mem[w_next];
                            r_cnt  <= w_next;
                            r_last <= (w_next == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = (r_state == SEND);
    assign done            = r_done;
    assign m_axis.m_valid  = r_valid;
    assign m_axis.m_data   = r_data;
    assign m_axis.m_last   = r_last;

endmodule

// File: tb/tb_axis_xk_tx.sv
// Self-checking bench for axis_xk_tx (R=C=2, K=3); expected beats come from a row-array model.
`timescale 1ns/1ps
module tb_axis_xk_tx;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int K  = 3;
    localparam int WX = 8;
    localparam int WK = 8;
    localparam int WB = WX*R + WK*C;
    localparam int WA = 2;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          w_en   = 1'b0;
    logic [WA-1:0] w_addr = '0;
    logic [WB-1:0] w_data = '0;
    logic          start  = 1'b0;
    logic          busy;
    logic          done;
`ifdef AXIS_XK_TX_LOOP_EN
    logic          loop   = 1'b0;
`endif

    axis_xk_tx_if #(.WB(WB)) m_if ();

    axis_xk_tx #(.R(R), .C(C), .K(K), .WX(WX), .WK(WK)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .start  (start),
`ifdef AXIS_XK_TX_LOOP_EN
        .loop   (loop),
`endif
        .busy   (busy),
        .done   (done),
        .m_axis (m_if)
    );

    always #5 clk = ~clk;

    // Model: the packet is simply the rows the bench last wrote while idle, in order.
    logic [WB-1:0] tb_mem [K];
    int n_pass  = 0;
    int n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input logic [WB-1:0] data);
        w_en   = 1'b1;
        w_addr = WA'(addr);
        w_data = data;
        tick();
        w_en   = 1'b0;
        tb_mem[addr] = data;
    endtask

    task automatic fill_random();
        for (int i = 0; i < K; i++) write_row(i, WB'($urandom()));
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_if.m_valid); else n_pass++;
        n_total++; if (m_if.m_last !== 1'b0) $display("FAIL rst_last: got %b want 0", m_if.m_last); else n_pass++;
        n_total++; if (m_if.m_data !== '0) $display("FAIL rst_data: got %h want 0", m_if.m_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        write_row(0, 32'h04030201);
        write_row(1, 32'h08070605);
        write_row(2, 32'h0C0B0A09);
        m_if.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < K; i++) begin
            n_total++; if (m_if.m_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, m_if.m_valid); else n_pass++;
            n_total++; if (m_if.m_data !== tb_mem[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, m_if.m_data, tb_mem[i]); else n_pass++;
            n_total++; if (m_if.m_last !== (i == K-1)) $display("FAIL b2b_last[%0d]: got %b want %b", i, m_if.m_last, (i == K-1)); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL b2b_early_done[%0d]: got %b want 0", i, done); else n_pass++;
            tick();
        end
        n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", m_if.m_valid); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL b2b_done_pulse: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_stall();
        int            beats = 0;
        int            lasts = 0;
        int            cyc   = 0;
        bit            pend  = 1'b0;
        bit            stalled = 1'b0;
        bit            rdy;
        logic [WB-1:0] held = '0;
        logic          held_last = 1'b0;
        m_if.m_ready = 1'b0;
        start = 1'b1;
        tick();
        while (cyc < 400) begin
            n_total++; if (done !== pend) $display("FAIL stall_done[c%0d]: got %b want %b", cyc, done, pend); else n_pass++;
            if (pend) break;
            if (stalled) begin
                n_total++; if (m_if.m_valid !== 1'b1) $display("FAIL stall_hold_valid[c%0d]: got %b want 1", cyc, m_if.m_valid); else n_pass++;
                n_total++; if (m_if.m_data !== held) $display("FAIL stall_hold_data[c%0d]: got %h want %h", cyc, m_if.m_data, held); else n_pass++;
                n_total++; if (m_if.m_last !== held_last) $display("FAIL stall_hold_last[c%0d]: got %b want %b", cyc, m_if.m_last, held_last); else n_pass++;
            end
            rdy = ($urandom_range(0, 99) < 30);
            m_if.m_ready = rdy;
            stalled = 1'b0;
            if (m_if.m_valid === 1'b1 && rdy) begin
                if (beats < K) begin
                    n_total++; if (m_if.m_data !== tb_mem[beats]) $display("FAIL stall_data[%0d]: got %h want %h", beats, m_if.m_data, tb_mem[beats]); else n_pass++;
                    n_total++; if (m_if.m_last !== (beats == K-1)) $display("FAIL stall_last[%0d]: got %b want %b", beats, m_if.m_last, (beats == K-1)); else n_pass++;
                    if (beats == K-1) pend = 1'b1;
                end else begin
                    n_total++; $display("FAIL stall_extra_beat[%0d]: got %h want none", beats, m_if.m_data);
                end
                if (m_if.m_last === 1'b1) lasts++;
                beats++;
            end else if (m_if.m_valid === 1'b1) begin
                stalled   = 1'b1;
                held      = m_if.m_data;
                held_last = m_if.m_last;
            end
            // Random start pulses while sending must not disturb the packet.
            start = pend ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        start = 1'b0;
        m_if.m_ready = 1'b0;
        n_total++; if (!pend) $display("FAIL stall_timeout: got %0d beats want %0d within 400 cycles", beats, K); else n_pass++;
        n_total++; if (beats != K) $display("FAIL stall_beats: got %0d want %0d", beats, K); else n_pass++;
        n_total++; if (lasts != 1) $display("FAIL stall_lasts: got %0d want 1", lasts); else n_pass++;
        tick();
    endtask

    task automatic test_write_during_send();
        fill_random();
        m_if.m_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        w_en   = 1'b1;
        w_addr = 2'd1;
        w_data = '1;
        tick();
        w_en = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL wds_busy: got %b want 1", busy); else n_pass++;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < K; i++) begin
            n_total++; if (m_if.m_data !== tb_mem[i]) $display("FAIL wds_data[%0d]: got %h want %h", i, m_if.m_data, tb_mem[i]); else n_pass++;
            tick();
        end
        n_total++; if (done !== 1'b1) $display("FAIL wds_done: got %b want 1", done); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < K; i++) begin
            n_total++; if (m_if.m_data !== tb_mem[i]) $display("FAIL wds_next_data[%0d]: got %h want %h", i, m_if.m_data, tb_mem[i]); else n_pass++;
            tick();
        end
        m_if.m_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        fill_random();
        m_if.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_total++; if (m_if.m_data !== tb_mem[2]) $display("FAIL abort_pre_data: got %h want %h", m_if.m_data, tb_mem[2]); else n_pass++;
        rstn = 1'b0;
        #1;
        n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", m_if.m_valid); else n_pass++;
        n_total++; if (m_if.m_last !== 1'b0) $display("FAIL abort_last: got %b want 0", m_if.m_last); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (m_if.m_data !== '0) $display("FAIL abort_data: got %h want 0", m_if.m_data); else n_pass++;
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (done !== 1'b0) $display("FAIL abort_no_done[%0d]: got %b want 0", i, done); else n_pass++;
            n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL abort_idle_valid[%0d]: got %b want 0", i, m_if.m_valid); else n_pass++;
        end
        // Buffer is undefined after reset, so rewrite before the next packet.
        fill_random();
        rstn = 1'b0;
        #2;
        rstn  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (m_if.m_valid !== 1'b1) $display("FAIL first_start_valid: got %b want 1", m_if.m_valid); else n_pass++;
        n_total++; if (m_if.m_data !== tb_mem[0]) $display("FAIL first_start_data: got %h want %h", m_if.m_data, tb_mem[0]); else n_pass++;
        for (int i = 0; i < K; i++) tick();
        n_total++; if (done !== 1'b1) $display("FAIL first_start_done: got %b want 1", done); else n_pass++;
        tick();
    endtask

    task automatic test_start_on_done();
        int cyc = 0;
        fill_random();
        m_if.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_total++; if (done !== 1'b1) $display("FAIL sod_timeout: got done=%b want 1 within 20 cycles", done); else n_pass++;
        n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL sod_gap_valid: got %b want 0", m_if.m_valid); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (m_if.m_valid !== 1'b1) $display("FAIL sod_valid: got %b want 1", m_if.m_valid); else n_pass++;
        n_total++; if (m_if.m_data !== tb_mem[0]) $display("FAIL sod_data: got %h want %h", m_if.m_data, tb_mem[0]); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL sod_busy: got %b want 1", busy); else n_pass++;
        for (int i = 0; i < K; i++) tick();
        n_total++; if (done !== 1'b1) $display("FAIL sod_done2: got %b want 1", done); else n_pass++;
        m_if.m_ready = 1'b0;
        tick();
    endtask

`ifdef AXIS_XK_TX_LOOP_EN
    task automatic test_loop();
        fill_random();
        m_if.m_ready = 1'b1;
        loop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2*K; i++) begin
            if (i == 2*K-1) loop = 1'b0;
            n_total++; if (m_if.m_valid !== 1'b1) $display("FAIL loop_valid[%0d]: got %b want 1", i, m_if.m_valid); else n_pass++;
            n_total++; if (m_if.m_data !== tb_mem[i % K]) $display("FAIL loop_data[%0d]: got %h want %h", i, m_if.m_data, tb_mem[i % K]); else n_pass++;
            n_total++; if (m_if.m_last !== ((i % K) == K-1)) $display("FAIL loop_last[%0d]: got %b want %b", i, m_if.m_last, ((i % K) == K-1)); else n_pass++;
            n_total++; if (done !== (i == K)) $display("FAIL loop_done[%0d]: got %b want %b", i, done, (i == K)); else n_pass++;
            tick();
        end
        n_total++; if (m_if.m_valid !== 1'b0) $display("FAIL loop_end_valid: got %b want 0", m_if.m_valid); else n_pass++;
        n_total++; if (done !== 1'b1) $display("FAIL loop_end_done: got %b want 1", done); else n_pass++;
        m_if.m_ready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        m_if.m_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_write_during_send();
        test_reset_abort();
        test_start_on_done();
`ifdef AXIS_XK_TX_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
